// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with start-glitch rejection, framing-error and overrun
// reporting, and a one-byte ready/valid holding register.
module uart_rx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_rd_data,
    output logic       uart_rd_valid,
    input  logic       uart_rd_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int BIT_CNT  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CW       = $clog2(BIT_CNT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_CNT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rxs;

    assign rxs = sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync          <= 2'b11;
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            uart_rd_data  <= '0;
            uart_rd_valid <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            sync      <= {sync[0], uart_rxd};
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (uart_rd_valid && uart_rd_ready)
                uart_rd_valid <= 1'b0;
            case (state)
                IDLE: if (!rxs) begin
                    cnt   <= '0;
                    state <= START;
                end
                START: if (cnt == HALF_END) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= rxs ? IDLE : DATA;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == BIT_END) begin
                    cnt   <= '0;
                    shreg <= {rxs, shreg[7:1]};
                    idx   <= idx + 1'b1;
                    if (idx == 3'd7) state <= STOP;
                end else cnt <= cnt + 1'b1;
                STOP: if (cnt == BIT_END) begin
                    cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                        // a same-cycle read frees the register, so the new byte replaces the old
                        if (!uart_rd_valid || uart_rd_ready) begin
                            uart_rd_data  <= shreg;
                            uart_rd_valid <= 1'b1;
                        end else overrun <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BRK;
                    end
                end else cnt <= cnt + 1'b1;
                BRK: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames through uart_rx at a reduced baud divisor (64 clocks/bit)
// with hand-computed expected bytes, pulse counts and latency.
module tb_uart_rx;
    localparam int CLK_FREQ  = 6400000;
    localparam int BAUD_RATE = 100000;
    localparam int BIT       = 64;
    localparam int LAT       = 2 + 32 + 9 * 64 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rd_ready = 1'b1;
    logic [7:0] uart_rd_data;
    logic       uart_rd_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int v_rise = 0;
    int vcyc = 0;
    int ferr_n = 0;
    int ovr_n = 0;
    int both_n = 0;
    logic v_prev = 1'b0;
    logic [7:0] rx_q[$];

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk(clk),
        .rst(rst),
        .uart_rxd(uart_rxd),
        .uart_rd_data(uart_rd_data),
        .uart_rd_valid(uart_rd_valid),
        .uart_rd_ready(uart_rd_ready),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uart_rd_valid && !v_prev) v_rise = cyc;
        v_prev = uart_rd_valid;
        if (uart_rd_valid) vcyc++;
        if (uart_rd_valid && uart_rd_ready) rx_q.push_back(uart_rd_data);
        if (frame_err) ferr_n++;
        if (overrun) ovr_n++;
        if (frame_err && overrun) both_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b);
        hold(1'b1, BIT);
    endtask

    logic [7:0] hello[12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C,
                              8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};
    int base, t0, f0, v0, o0;

    initial begin
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", uart_rd_data, 8'h00);
        check("rst_valid", uart_rd_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst = 1'b1;
        hold(1'b1, 4);

        t0 = cyc;
        v0 = vcyc;
        send(8'h55);
        hold(1'b1, 2 * BIT);
        check("f55_count", rx_q.size(), 1);
        check("f55_data", rx_q[0], 8'h55);
        check("f55_width", vcyc - v0, 1);
        check("f55_lat_ok", ((v_rise - t0) >= LAT - 2) && ((v_rise - t0) <= LAT + 2), 1'b1);
        check("f55_ferr", ferr_n, 0);
        check("f55_ovr", ovr_n, 0);

        base = rx_q.size();
        foreach (hello[i]) send(hello[i]);
        hold(1'b1, 2 * BIT);
        check("hello_count", rx_q.size() - base, 12);
        for (int i = 0; i < 12; i++) check($sformatf("hello_%0d", i), rx_q[base + i], hello[i]);
        check("hello_errs", ferr_n + ovr_n, 0);

        base = rx_q.size();
        hold(1'b0, 20);
        hold(1'b1, 2 * BIT);
        check("glitch_nobyte", rx_q.size() - base, 0);
        check("glitch_ferr", ferr_n, 0);
        send(8'hA3);
        hold(1'b1, 2 * BIT);
        check("a3_count", rx_q.size() - base, 1);
        check("a3_data", rx_q[base], 8'hA3);

        base = rx_q.size();
        send_bits(8'h0F);
        hold(1'b0, 2 * BIT);
        hold(1'b1, 2 * BIT);
        check("brk_ferr", ferr_n, 1);
        check("brk_nobyte", rx_q.size() - base, 0);
        send(8'h3C);
        hold(1'b1, 2 * BIT);
        check("3c_count", rx_q.size() - base, 1);
        check("3c_data", rx_q[base], 8'h3C);
        check("3c_ferr", ferr_n, 1);

        base = rx_q.size();
        uart_rd_ready = 1'b0;
        send(8'h11);
        hold(1'b1, 2 * BIT);
        check("ovr_valid1", uart_rd_valid, 1'b1);
        check("ovr_data1", uart_rd_data, 8'h11);
        send(8'h22);
        hold(1'b1, 2 * BIT);
        check("ovr_pulse", ovr_n, 1);
        check("ovr_keep", uart_rd_data, 8'h11);
        check("ovr_valid2", uart_rd_valid, 1'b1);
        uart_rd_ready = 1'b1;
        @(negedge clk);
        check("ovr_hs_valid", uart_rd_valid, 1'b1);
        @(negedge clk);
        check("ovr_drop_valid", uart_rd_valid, 1'b0);
        check("ovr_read_count", rx_q.size() - base, 1);
        check("ovr_read_data", rx_q[base], 8'h11);

        @(posedge clk);
        #1;
        uart_rd_ready = 1'b0;
        send(8'h5A);
        hold(1'b1, 2 * BIT);
        check("pre_rst_valid", uart_rd_valid, 1'b1);
        base = rx_q.size();
        f0 = ferr_n;
        o0 = ovr_n;
        send_bits(8'h00);
        hold(1'b1, BIT / 2);
        rst = 1'b0;
        #2;
        check("mid_rst_valid", uart_rd_valid, 1'b0);
        check("mid_rst_data", uart_rd_data, 8'h00);
        hold(1'b1, 3);
        rst = 1'b1;
        hold(1'b1, 5 * BIT);
        uart_rd_ready = 1'b1;
        hold(1'b1, 4);
        check("mid_rst_nobyte", rx_q.size() - base, 0);
        send(8'h7E);
        hold(1'b1, 2 * BIT);
        check("7e_count", rx_q.size() - base, 1);
        check("7e_data", rx_q[base], 8'h7E);
        check("7e_errs", (ferr_n - f0) + (ovr_n - o0), 0);
        check("never_both", both_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
